// File: rtl/sel_arb_mux_if.sv
// sel_arb_mux_if: channel inputs and registered output handshake bundle.
`timescale 1ns/1ps
interface sel_arb_mux_if #(
   parameter int WIDTH = 5,
   parameter int CH    = 3,
   parameter int SELW  = 2
);
   logic                  mode;
   logic [SELW-1:0]       sel;
   logic [CH-1:0]         in_valid;
   logic [CH*WIDTH-1:0]   in_data;
   logic [CH-1:0]         in_ready;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic [SELW-1:0]       out_ch;
   logic                  out_ready;

   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/sel_arb_mux.sv
// sel_arb_mux: registered CH:1 selector, explicit or round-robin grant.
// Define SEL_ARB_MUX_CNT_EN to add the 16-bit xfer_cnt transfer counter.
`timescale 1ns/1ps
module sel_arb_mux #(
   parameter int WIDTH = 5,
   parameter int CH    = 3,
   parameter int SELW  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef SEL_ARB_MUX_CNT_EN
   output logic [15:0]  xfer_cnt,
`endif
   sel_arb_mux_if.slave bus
);
   localparam int NS = 2**SELW;

   logic [NS-1:0]    vld;
   logic [WIDTH-1:0] dat [NS];
   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  rr_g;
   logic [SELW-1:0]  ex_g;
   logic [SELW-1:0]  g;
   logic [SELW:0]    idx;
   logic             rr_hit;
   logic             gnt_ok;
   logic             load;
   logic             xfer;
   logic             ov;
   logic [WIDTH-1:0] od;
   logic [SELW-1:0]  oc;

   // Pad channels to the full select range so any code indexes safely.
   always_comb begin
      vld = '0;
      vld[CH-1:0] = bus.in_valid;
      for (int i = 0; i < NS; i++) dat[i] = '0;
      for (int i = 0; i < CH; i++) dat[i] = bus.in_data[i*WIDTH +: WIDTH];
   end

   always_comb begin
      rr_g   = '0;
      rr_hit = 1'b0;
      idx    = '0;
      for (int k = 1; k <= CH; k++) begin
         idx = {1'b0, ptr} + (SELW+1)'(k);
         if (idx >= (SELW+1)'(CH)) idx = idx - (SELW+1)'(CH);
         if (!rr_hit && vld[idx[SELW-1:0]]) begin
            rr_hit = 1'b1;
            rr_g   = idx[SELW-1:0];
         end
      end
   end

   assign ex_g   = ({1'b0, bus.sel} < (SELW+1)'(CH)) ? bus.sel : '0;
   assign g      = bus.mode ? rr_g : ex_g;
   assign gnt_ok = bus.mode ? rr_hit : 1'b1;
   assign load   = !ov || bus.out_ready;
   assign xfer   = load && vld[g];

   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < CH; i++)
         bus.in_ready[i] = rst_n && load && gnt_ok && (g == SELW'(i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov  <= 1'b0;
         od  <= '0;
         oc  <= '0;
         ptr <= SELW'(CH-1);
      end else if (load) begin
         ov <= xfer;
         if (xfer) begin
            od <= dat[g];
            oc <= g;
            if (bus.mode) ptr <= g;
         end
      end
   end

`ifdef SEL_ARB_MUX_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    xfer_cnt <= '0;
      else if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
   end
`endif

   assign bus.out_valid = ov;
   assign bus.out_data  = od;
   assign bus.out_ch    = oc;
endmodule

// File: tb/tb_sel_arb_mux.sv
// tb_sel_arb_mux: scoreboard bench for sel_arb_mux.
`timescale 1ns/1ps
module tb_sel_arb_mux;
   localparam int W = 5;
   localparam int N = 3;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sel_arb_mux_if #(.WIDTH(W), .CH(N), .SELW(S)) bus ();
`ifdef SEL_ARB_MUX_CNT_EN
   logic [15:0] xfer_cnt;
`endif

   sel_arb_mux #(.WIDTH(W), .CH(N), .SELW(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef SEL_ARB_MUX_CNT_EN
      .xfer_cnt (xfer_cnt),
`endif
      .bus      (bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   logic [S+W-1:0] sb [$];
   logic m_valid;
   int m_ptr;
   logic [15:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic int rr_pick(input int p, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      sb.delete();
      m_valid = 1'b0;
      m_ptr   = N - 1;
      m_cnt   = '0;
   endtask

   // One cycle: check outputs and in_ready, update model, wait for negedge.
   task automatic step();
      int g;
      logic ld;
      logic [N-1:0] exp_rdy;
      logic [S+W-1:0] w;
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
`ifdef SEL_ARB_MUX_CNT_EN
      check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
      if (bus.out_valid) begin
         check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            w = sb[0];
            check("out_ch", 32'(bus.out_ch), 32'(w[S+W-1:W]));
            check("out_data", 32'(bus.out_data), 32'(w[W-1:0]));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
      ld = !m_valid || bus.out_ready;
      if (bus.mode) g = rr_pick(m_ptr, bus.in_valid);
      else g = (int'(bus.sel) < N) ? int'(bus.sel) : 0;
      exp_rdy = (ld && g >= 0) ? N'(1 << g) : '0;
      check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (ld) begin
         if (g >= 0 && bus.in_valid[g]) begin
            sb.push_back({S'(g), bus.in_data[g*W +: W]});
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
            if (bus.mode) m_ptr = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.mode      = 1'b1;
      bus.sel       = '0;
      bus.in_valid  = '1;
      bus.in_data   = {5'h1C, 5'h0B, 5'h05};
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_out_ch", 32'(bus.out_ch), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         step();
         #1;
         check("rr_seq", 32'(bus.out_ch), 32'(i % 3));
      end

      bus.mode = 1'b0;
      bus.sel  = 2'd2;
      step();
      #1;
      check("ex_sel2_data", 32'(bus.out_data), 32'h1C);
      check("ex_sel2_ch", 32'(bus.out_ch), 32'd2);
      bus.sel = 2'd3;
      step();
      #1;
      check("ex_sel3_data", 32'(bus.out_data), 32'h05);
      check("ex_sel3_ch", 32'(bus.out_ch), 32'd0);

      bus.sel       = 2'd1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         check("bp_hold", 32'(bus.out_data), 32'h05);
         check("bp_rdy0", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      #1;
      check("nobubble_v", 32'(bus.out_valid), 32'd1);
      check("nobubble_d", 32'(bus.out_data), 32'h0B);

      bus.mode     = 1'b1;
      bus.in_valid = 3'b001;
      step();
      bus.in_valid = 3'b101;
      step();
      #1;
      check("sparse_2", 32'(bus.out_ch), 32'd2);
      step();
      #1;
      check("sparse_0", 32'(bus.out_ch), 32'd0);
      bus.in_valid = 3'b000;
      step();
      #1;
      check("drain", 32'(bus.out_valid), 32'd0);

      for (int i = 0; i < 300; i++) begin
         bus.mode      = 1'($urandom_range(0, 1));
         bus.sel       = 2'($urandom_range(0, 3));
         bus.in_valid  = 3'($urandom_range(0, 7));
         bus.in_data   = 15'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      bus.mode      = 1'b1;
      bus.in_valid  = '1;
      bus.in_data   = {5'h11, 5'h12, 5'h13};
      bus.out_ready = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_data", 32'(bus.out_data), 32'd0);
      check("arst_ch", 32'(bus.out_ch), 32'd0);
      check("arst_rdy", 32'(bus.in_ready), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      step();
      #1;
      check("post_rst_ch", 32'(bus.out_ch), 32'd0);
      check("post_rst_d", 32'(bus.out_data), 32'h13);

`ifdef SEL_ARB_MUX_CNT_EN
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 70000; i++) step();
      #1;
      check("cnt_wrap", 32'(xfer_cnt), 32'd4464);
`endif

      bus.in_valid = '0;
      repeat (2) step();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sel_arb_mux.md
# sel_arb_mux

Parametrised, registered N-channel selector with valid/ready handshaking, replacing the fixed 3:1 register-address select. It selects one of `CH` input channels, either by an explicit select code or by round-robin arbitration. The chosen word goes into a one-entry output register. It sits between datapath producers, such as write-address or result sources, and a stall-capable pipeline stage that consumes one word per cycle.

## Interface
Parameters:
- `WIDTH`, 5, data width per channel.
- `CH`, 3, number of input channels (2..2**SELW).
- `SELW`, 2, width of the `sel` and `out_ch` fields.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = explicit select, 1 = round-robin.
- `sel` in SELW: channel code in explicit mode.
- `in_valid` in CH: per-channel valid.
- `in_data` in CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready` out CH: per-channel accept; combinational.
- `out_valid` out 1: output register holds a word.
- `out_data` out WIDTH: registered data.
- `out_ch` out SELW: index of the channel that produced `out_data`.
- `out_ready` in 1: consumer accepts the word.

## Operation
- `load = !out_valid || out_ready`.
- Grant selection is combinational, every cycle:
  - Explicit mode: the granted channel is `sel`. Any `sel >= CH` maps to channel 0.
  - Round-robin mode: the granted channel is the first i with `in_valid[i]`, searching from `ptr+1` upward with wrap modulo CH.
- `in_ready[g] = load` for the granted channel g only. All other `in_ready` bits are 0. In explicit mode, `in_ready[g]` asserts even if `in_valid[g]=0`.
- A transfer occurs when `load && in_valid[g]`. On transfer:
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
  - In round-robin mode, `ptr <= g`.
- When `load` is high and there is no transfer, `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- When `load` is low (`out_valid && !out_ready`), all outputs hold and no `in_ready` bit asserts.
- `ptr` is updated only by round-robin transfers. Switching `mode` never resets `ptr`.
- Reset values: `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=CH-1`, so channel 0 has first priority after reset.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`/`out_data`.
- Throughput: 1 word per cycle while `out_ready` is held at 1.
- Simultaneous drain and refill: if `out_valid && out_ready` and a new transfer occurs in the same cycle, the new word replaces the old one at the edge with no bubble.
- Backpressure: while `out_valid && !out_ready`, the output is stable and `in_ready` is all zero.
- Wrap-around: with `ptr=CH-1`, the search starts at channel 0.
- `mode`/`sel` changes take effect in the same cycle's grant. There is no registered mode state.
- Reset asserted mid-operation: the buffered word is dropped, outputs go to their reset values immediately (asynchronously), and `in_ready` is 0 while `rst_n=0`.

## Configuration
- Macro `SEL_ARB_MUX_CNT_EN`.
- When defined, adds port `xfer_cnt` out 16:
  - Counts input transfers.
  - Resets to 0 and increments by 1 on each transfer.
  - Wraps from 16'hFFFF to 0.
- When undefined, the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold `rst_n=0` with all `in_valid=1` -> `out_valid=0`, `out_data=0`, `out_ch=0`, `in_ready=0`. Release reset -> first round-robin grant goes to channel 0.
- Explicit mode, `CH=3`, `WIDTH=5`:
  - `in_data` = {5'h1C, 5'h0B, 5'h05}, `sel=2`, all valid, `out_ready=1` -> next cycle `out_data=5'h1C`, `out_ch=2`.
  - `sel=3` -> `out_data=5'h05`, `out_ch=0`.
- Round-robin, all valid, `out_ready=1` for 6 cycles -> `out_ch` sequence 0,1,2,0,1,2 with `out_valid` high continuously.
- Backpressure: `out_ready=0` for 3 cycles after a load -> `out_data` stable, `in_ready=0`. Raise `out_ready` -> next word loads in the same cycle as the drain, with no bubble.
- Sparse round-robin: only `in_valid[2]` and `in_valid[0]` set, `ptr=0` -> grant 2, then 0. Dropping all valids -> `out_valid` falls after one `out_ready` cycle.
- With `SEL_ARB_MUX_CNT_EN`: 70000 back-to-back transfers -> `xfer_cnt = 70000 mod 65536 = 4464`.
